regfile_multi: RTL and testbench

- Parametrised successor of the team's 32x32 two-read/one-write register file.
- Adds configurable width, depth and read-port count; byte-enable writes; optional hardwired-zero register 0; optional write-to-read bypass.
- Adds a sequenced clear engine that sweeps the array to zero one entry per cycle with busy/done handshake, replacing the single-cycle whole-array reset.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port).

---
 rtl/regfile_pkg.sv | 36 +++
 rtl/regfile_clr_seq.sv | 81 ++++++++
 rtl/regfile_multi.sv | 106 ++++++++++
 tb/tb_regfile_multi.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types, constants and helpers for the multi-port register file.
//   clr_state_t : clear sequencer states (IDLE, CLEAR)
//   byte_merge  : per-byte select of new data over old data, driven by byte enables
// byte_merge is written at a fixed width of MERGE_W bits. Callers zero-extend
// their operands into it and truncate the result, so any DATA_W up to MERGE_W
// can share the one helper.
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int MERGE_W    = 256;
    localparam int MERGE_BE_W = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int b = 0; b < MERGE_BE_W; b++) begin
            if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// -----------------------------------------------------------------------------
// regfile_clr_seq
// Sequencer that sweeps the register array to zero, one entry per cycle.
// Ports:
//   Clk, Reset_n : clock, asynchronous active-low reset
//   Clr_Req      : single-cycle start request (ignored while a sweep runs)
//   Busy         : high for the whole sweep
//   Clr_Done     : one-cycle pulse while the last entry is being cleared
//   clr_en       : array clear strobe for this cycle
//   clr_addr     : entry cleared at the coming edge
// -----------------------------------------------------------------------------
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Clr_Req,
    output logic              Busy,
    output logic              Clr_Done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int              DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PENULT = ADDR_W'(DEPTH - 2);

    clr_state_t        state;
    logic [ADDR_W-1:0] count;
    logic              busy_r;
    logic              done_r;

    // Busy and Clr_Done are registered alongside the state; Clr_Done is set
    // on the edge that moves count onto the last entry, so it is high for
    // exactly the cycle in which that entry is cleared.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Clr_Req) begin
                        state  <= CLEAR;
                        count  <= '0;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (count == LAST) begin
                        // Stop here rather than letting count wrap.
                        state  <= IDLE;
                        count  <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end else begin
                        count  <= count + ADDR_W'(1);
                        done_r <= (count == PENULT);
                    end
                end
                default: begin
                    state  <= IDLE;
                    count  <= '0;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign Busy     = busy_r;
    assign Clr_Done = done_r;
    assign clr_en   = busy_r;
    assign clr_addr = count;

endmodule

// File: rtl/regfile_multi.sv
// -----------------------------------------------------------------------------
// regfile_multi
// Parametrised multi-read, single-write register file with byte-enable writes,
// optional hardwired-zero entry 0, optional write-to-read bypass and a
// sequenced clear engine.
// Ports:
//   Clk, Reset_n : clock, asynchronous active-low reset (zeroes every entry)
//   R_Addr       : NRD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   R_Data       : NRD packed read words, combinational from R_Addr
//   Write_Reg    : write strobe
//   W_Addr       : write address
//   W_Data       : write data
//   W_Be         : byte enables, bit b covers W_Data[8b+7:8b]
//   Clr_Req      : start a full clear sweep
//   Busy         : high while the sweep runs
//   Clr_Done     : one-cycle pulse on the last sweep cycle
// DATA_W must be a multiple of 8 and no wider than regfile_pkg::MERGE_W.
// -----------------------------------------------------------------------------
module regfile_multi
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [NRD*ADDR_W-1:0] R_Addr,
    output logic [NRD*DATA_W-1:0] R_Data,
    input  logic                  Write_Reg,
    input  logic [ADDR_W-1:0]     W_Addr,
    input  logic [DATA_W-1:0]     W_Data,
    input  logic [DATA_W/8-1:0]   W_Be,
    input  logic                  Clr_Req,
    output logic                  Busy,
    output logic                  Clr_Done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_act;
    logic              wr_commit;

    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        return DATA_W'(byte_merge(MERGE_W'(old_word), MERGE_W'(new_word),
                                  MERGE_BE_W'(be)));
    endfunction

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Clr_Req  (Clr_Req),
        .Busy     (Busy),
        .Clr_Done (Clr_Done),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // Writes are only live outside a sweep. A write coinciding with Clr_Req
    // still commits, because the sweep has not started at that edge.
    assign wr_act    = Write_Reg && !clr_en;
    assign wr_commit = wr_act && !((ZERO_REG != 0) && (W_Addr == '0));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_commit) begin
            mem[W_Addr] <= merge_word(mem[W_Addr], W_Data, W_Be);
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] word;

        assign ra = R_Addr[k*ADDR_W +: ADDR_W];

        // The zero-register override comes last so a bypass hit on
        // address 0 can never leak write data.
        always_comb begin
            word = mem[ra];
            if ((BYPASS != 0) && wr_act && (ra == W_Addr))
                word = merge_word(mem[ra], W_Data, W_Be);
            if ((ZERO_REG != 0) && (ra == '0))
                word = '0;
        end

        assign R_Data[k*DATA_W +: DATA_W] = word;
    end

endmodule

// File: tb/tb_regfile_multi.sv
module tb_regfile_multi;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [9:0]  R_Addr = '0;
    logic [63:0] R_Data;
    logic [63:0] R_Data2;
    logic        Write_Reg = 1'b0;
    logic [4:0]  W_Addr = '0;
    logic [31:0] W_Data = '0;
    logic [3:0]  W_Be = '0;
    logic        Clr_Req = 1'b0;
    logic        Busy, Clr_Done;
    logic        Busy2, Clr_Done2;

    int checks = 0;
    int passes = 0;

    always #5 Clk = ~Clk;

    regfile_multi dut (
        .Clk(Clk), .Reset_n(Reset_n), .R_Addr(R_Addr), .R_Data(R_Data),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .W_Be(W_Be),
        .Clr_Req(Clr_Req), .Busy(Busy), .Clr_Done(Clr_Done)
    );

    regfile_multi #(.ZERO_REG(0), .BYPASS(0)) dut_plain (
        .Clk(Clk), .Reset_n(Reset_n), .R_Addr(R_Addr), .R_Data(R_Data2),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .W_Be(W_Be),
        .Clr_Req(Clr_Req), .Busy(Busy2), .Clr_Done(Clr_Done2)
    );

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge Clk);
        Write_Reg = 1'b1; W_Addr = a; W_Data = d; W_Be = be;
        @(negedge Clk);
        Write_Reg = 1'b0; W_Be = '0;
    endtask

    task automatic set_raddr(input logic [4:0] p0, input logic [4:0] p1);
        R_Addr = {p1, p0};
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        set_raddr(5'd5, 5'd31);
        #1;
        checks++;
        if (R_Data !== 64'h0) $display("FAIL reset_rdata got %h expected %h", R_Data, 64'h0);
        else passes++;
        checks++;
        if (R_Data2 !== 64'h0) $display("FAIL reset_rdata_plain got %h expected %h", R_Data2, 64'h0);
        else passes++;
        checks++;
        if (Busy !== 1'b0 || Clr_Done !== 1'b0)
            $display("FAIL reset_busy got %b%b expected 00", Busy, Clr_Done);
        else passes++;
    endtask

    task automatic test_byte_write;
        do_write(5'd3, 32'hAABBCCDD, 4'hF);
        do_write(5'd3, 32'h11223344, 4'b0101);
        set_raddr(5'd3, 5'd3);
        #1;
        checks++;
        if (R_Data[31:0] !== 32'hAA22CC44) $display("FAIL byte_write got %h expected %h", R_Data[31:0], 32'hAA22CC44);
        else passes++;
        checks++;
        if (R_Data[63:32] !== 32'hAA22CC44) $display("FAIL byte_write_p1 got %h expected %h", R_Data[63:32], 32'hAA22CC44);
        else passes++;
        do_write(5'd3, 32'hFFFFFFFF, 4'h0);
        #1;
        checks++;
        if (R_Data2[31:0] !== 32'hAA22CC44) $display("FAIL be_zero_noop got %h expected %h", R_Data2[31:0], 32'hAA22CC44);
        else passes++;
    endtask

    task automatic test_zero_reg;
        do_write(5'd0, 32'hFFFFFFFF, 4'hF);
        set_raddr(5'd0, 5'd3);
        #1;
        checks++;
        if (R_Data[31:0] !== 32'h0) $display("FAIL zero_reg got %h expected %h", R_Data[31:0], 32'h0);
        else passes++;
        checks++;
        if (R_Data2[31:0] !== 32'hFFFFFFFF) $display("FAIL zero_reg_off got %h expected %h", R_Data2[31:0], 32'hFFFFFFFF);
        else passes++;
    endtask

    task automatic test_bypass;
        do_write(5'd7, 32'h12345678, 4'hF);
        @(negedge Clk);
        Write_Reg = 1'b1; W_Addr = 5'd7; W_Data = 32'hDEADBEEF; W_Be = 4'b0011;
        set_raddr(5'd7, 5'd3);
        #1;
        checks++;
        if (R_Data[31:0] !== 32'h1234BEEF) $display("FAIL bypass got %h expected %h", R_Data[31:0], 32'h1234BEEF);
        else passes++;
        checks++;
        if (R_Data[63:32] !== 32'hAA22CC44) $display("FAIL bypass_other_port got %h expected %h", R_Data[63:32], 32'hAA22CC44);
        else passes++;
        checks++;
        if (R_Data2[31:0] !== 32'h12345678) $display("FAIL no_bypass got %h expected %h", R_Data2[31:0], 32'h12345678);
        else passes++;
        // Bypass onto address 0 must stay suppressed.
        W_Addr = 5'd0; set_raddr(5'd0, 5'd3);
        #1;
        checks++;
        if (R_Data[31:0] !== 32'h0) $display("FAIL bypass_zero_reg got %h expected %h", R_Data[31:0], 32'h0);
        else passes++;
        W_Addr = 5'd7; set_raddr(5'd7, 5'd3);
        @(negedge Clk);
        Write_Reg = 1'b0; W_Be = '0;
        #1;
        checks++;
        if (R_Data2[31:0] !== 32'h1234BEEF) $display("FAIL after_edge got %h expected %h", R_Data2[31:0], 32'h1234BEEF);
        else passes++;
    endtask

    task automatic test_clear_sweep;
        int busy_cycles;
        int done_cycle;
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i + 1), 4'hF);
        @(negedge Clk);
        Clr_Req = 1'b1;
        @(negedge Clk);
        Clr_Req = 1'b0;
        busy_cycles = 0;
        done_cycle  = 0;
        set_raddr(5'd20, 5'd9);
        for (int c = 1; c <= 32; c++) begin
            if (c > 1) @(negedge Clk);
            if (c == 5) begin
                Write_Reg = 1'b1; W_Addr = 5'd9; W_Data = 32'hCAFEF00D; W_Be = 4'hF;
            end else begin
                Write_Reg = 1'b0; W_Be = '0;
            end
            #1;
            if (Busy === 1'b1) busy_cycles++;
            if (Clr_Done === 1'b1) begin
                if (done_cycle != 0) done_cycle = -1;
                else done_cycle = c;
            end
            if (c == 5) begin
                checks++;
                if (R_Data[63:32] !== 32'd10) $display("FAIL no_bypass_in_clear got %h expected %h", R_Data[63:32], 32'd10);
                else passes++;
            end
            if (c == 6) begin
                checks++;
                if (R_Data[63:32] !== 32'd10) $display("FAIL write_dropped got %h expected %h", R_Data[63:32], 32'd10);
                else passes++;
            end
            if (c == 10) begin
                checks++;
                if (R_Data[31:0] !== 32'd21) $display("FAIL mid_sweep_e20 got %h expected %h", R_Data[31:0], 32'd21);
                else passes++;
            end
            if (c == 22) begin
                checks++;
                if (R_Data[31:0] !== 32'd0) $display("FAIL e20_cleared got %h expected %h", R_Data[31:0], 32'd0);
                else passes++;
            end
        end
        checks++;
        if (busy_cycles != 32) $display("FAIL busy_len got %0d expected %0d", busy_cycles, 32);
        else passes++;
        checks++;
        if (done_cycle != 32) $display("FAIL done_cycle got %0d expected %0d", done_cycle, 32);
        else passes++;
        @(negedge Clk);
        #1;
        checks++;
        if (Busy !== 1'b0 || Clr_Done !== 1'b0)
            $display("FAIL busy_after got %b%b expected 00", Busy, Clr_Done);
        else passes++;
        for (int a = 0; a < 32; a++) begin
            set_raddr(5'(a), 5'(31 - a));
            #1;
            checks++;
            if (R_Data !== 64'h0 || R_Data2 !== 64'h0)
                $display("FAIL cleared_entry_%0d got %h/%h expected 0", a, R_Data, R_Data2);
            else passes++;
        end
    endtask

    task automatic test_clr_with_write;
        int n;
        @(negedge Clk);
        Clr_Req = 1'b1; Write_Reg = 1'b1; W_Addr = 5'd12; W_Data = 32'h00000055; W_Be = 4'hF;
        @(negedge Clk);
        Clr_Req = 1'b0; Write_Reg = 1'b0; W_Be = '0;
        set_raddr(5'd12, 5'd12);
        #1;
        checks++;
        if (R_Data2[31:0] !== 32'h55) $display("FAIL clr_write_commit got %h expected %h", R_Data2[31:0], 32'h55);
        else passes++;
        n = 0;
        while (Busy !== 1'b0 && n < 40) begin
            @(negedge Clk);
            #1;
            n++;
        end
        checks++;
        if (Busy !== 1'b0) $display("FAIL clr_write_timeout got busy=%b expected 0", Busy);
        else passes++;
        checks++;
        if (R_Data2[31:0] !== 32'h0) $display("FAIL clr_write_zeroed got %h expected %h", R_Data2[31:0], 32'h0);
        else passes++;
    endtask

    task automatic test_reset_mid_clear;
        int n;
        int saw_done;
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA0 + 32'(i), 4'hF);
        @(negedge Clk);
        Clr_Req = 1'b1;
        @(negedge Clk);
        Clr_Req = 1'b0;
        saw_done = 0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge Clk);
            if (Clr_Done === 1'b1) saw_done = 1;
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0) $display("FAIL async_busy got %b expected 0", Busy);
        else passes++;
        set_raddr(5'd15, 5'd31);
        #1;
        checks++;
        if (R_Data2 !== 64'h0) $display("FAIL abort_zeroed got %h expected %h", R_Data2, 64'h0);
        else passes++;
        @(negedge Clk);
        if (Clr_Done === 1'b1) saw_done = 1;
        Reset_n = 1'b1;
        repeat (25) begin
            @(negedge Clk);
            if (Clr_Done === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done != 0 || Busy !== 1'b0) $display("FAIL abort_no_done got done=%0d busy=%b expected 0/0", saw_done, Busy);
        else passes++;
        do_write(5'd31, 32'h77, 4'hF);
        @(negedge Clk);
        Clr_Req = 1'b1;
        @(negedge Clk);
        Clr_Req = 1'b0;
        n = 1;
        #1;
        while (Clr_Done !== 1'b1 && n < 40) begin
            @(negedge Clk);
            #1;
            n++;
        end
        checks++;
        if (n != 32) $display("FAIL restart_from_zero got done at cycle %0d expected %0d", n, 32);
        else passes++;
        set_raddr(5'd31, 5'd0);
        #1;
        checks++;
        if (R_Data2[31:0] !== 32'h77) $display("FAIL last_entry_before_edge got %h expected %h", R_Data2[31:0], 32'h77);
        else passes++;
        @(negedge Clk);
        #1;
        checks++;
        if (R_Data2[31:0] !== 32'h0 || Busy !== 1'b0)
            $display("FAIL last_entry_cleared got %h busy=%b expected 0/0", R_Data2[31:0], Busy);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_zero_reg();
        test_bypass();
        test_clear_sweep();
        test_clr_with_write();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
